// File: rtl/vehicle_pkg.sv
// Shared vehicle drive definitions: motor control state encoding and
// direction constants used by the PWM ramp block and its neighbours.
package vehicle_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP    = 3'd1,
    RUN     = 3'd2,
    REVERSE = 3'd3,
    DEAD    = 3'd4
  } motor_state_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

endpackage

// File: rtl/tick_sync_edge.sv
// Brings an asynchronous divided clock into the clk domain and turns each
// rising edge into a single-cycle pulse. Reusable for any divider output.
module tick_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  // Two metastability flops, then one more flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/motor_pwm_ramp.sv
// Motor PWM generator with soft duty ramping and safe direction reversal.
// The PWM time base advances on each rising edge of tick_in (a divided
// clock, synchronized here). Duty only changes at period boundaries; a
// direction change ramps duty to zero before dir_out flips.
// Optional build macro MOTOR_PWM_DEADTIME_EN inserts DEADTIME_TICKS ticks of
// forced-low PWM between duty reaching zero and the direction flip.
module motor_pwm_ramp
  import vehicle_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int RAMP_STEP      = 1,
  parameter int DEADTIME_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_cmd,
  input  logic             dir_cmd,
  output logic             pwm_out,
  output logic             dir_out,
  output logic [WIDTH-1:0] duty_cur,
  output logic             busy
);

  // Counter runs 0..2**WIDTH-2, so a period is 2**WIDTH-1 ticks and a
  // full-scale duty keeps the output permanently high.
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);
  localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(RAMP_STEP);

  // Degenerate settings leave an obviously named scope in the hierarchy.
  if (RAMP_STEP < 1 || DEADTIME_TICKS < 1) begin : g_bad_params
  end

  // Move cur toward tgt by STEP_V, landing exactly on tgt when closer than
  // one step; never overshoots, so no wrap past 0 or full scale.
  function automatic logic [WIDTH-1:0] step_toward(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] tgt
  );
    logic [WIDTH-1:0] gap;
    if (cur < tgt) begin
      gap = tgt - cur;
      return (gap <= STEP_V) ? tgt : cur + STEP_V;
    end else if (cur > tgt) begin
      gap = cur - tgt;
      return (gap <= STEP_V) ? tgt : cur - STEP_V;
    end
    return cur;
  endfunction

  motor_state_e     state;
  motor_state_e     state_nx;
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] cnt_adv;
  logic [WIDTH-1:0] duty_nx;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] duty_step;
  logic             dir_nx;
  logic             pwm_nx;
  logic             tick_pulse;
  logic             boundary;
  logic             dir_match;

  tick_sync_edge u_tick_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (tick_in),
    .pulse    (tick_pulse)
  );

  assign boundary  = tick_pulse && (period_cnt == CNT_LAST);
  assign cnt_adv   = !tick_pulse ? period_cnt :
                     (boundary ? '0 : period_cnt + 1'b1);
  assign dir_match = (dir_cmd == dir_out);
  // A pending reversal always drives duty toward zero first.
  assign target    = dir_match ? duty_cmd : '0;
  assign duty_step = step_toward(duty_cur, target);

`ifdef MOTOR_PWM_DEADTIME_EN
  localparam int DEAD_W = $clog2(DEADTIME_TICKS) + 1;

  logic [DEAD_W-1:0] dead_cnt;
  logic              dead_last;

  assign dead_last = (dead_cnt == DEAD_W'(DEADTIME_TICKS - 1));

  // Ticks spent in DEAD; restarts from zero on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dead_cnt <= '0;
    end else if (state != DEAD) begin
      dead_cnt <= '0;
    end else if (tick_pulse) begin
      dead_cnt <= dead_cnt + 1'b1;
    end
  end
`endif

  // Next-state, counter, duty and direction decisions.
  always_comb begin
    state_nx = state;
    cnt_nx   = period_cnt;
    duty_nx  = duty_cur;
    dir_nx   = dir_out;
    if (!enable) begin
      // Enable drop beats any coincident tick; direction is kept.
      state_nx = IDLE;
      cnt_nx   = '0;
      duty_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          // Duty is already zero, so a new direction applies at once.
          dir_nx   = dir_cmd;
          state_nx = RAMP;
        end
`ifdef MOTOR_PWM_DEADTIME_EN
        DEAD: begin
          cnt_nx = cnt_adv;
          if (dir_match) begin
            state_nx = RAMP;
          end else if (tick_pulse && dead_last) begin
            dir_nx   = ~dir_out;
            state_nx = RAMP;
          end
        end
`endif
        default: begin
          cnt_nx = cnt_adv;
          if (boundary) begin
            duty_nx = duty_step;
          end
          if (!dir_match) begin
            if (boundary && (duty_step == '0)) begin
`ifdef MOTOR_PWM_DEADTIME_EN
              state_nx = DEAD;
`else
              dir_nx   = ~dir_out;
              state_nx = RAMP;
`endif
            end else begin
              state_nx = REVERSE;
            end
          end else if (duty_nx == duty_cmd) begin
            state_nx = RUN;
          end else begin
            state_nx = RAMP;
          end
        end
      endcase
    end
  end

  // PWM is computed from the values the counter and duty are about to take,
  // keeping tick_in-to-pwm_out latency at three clocks.
  assign pwm_nx = enable && (cnt_nx < duty_nx);

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      period_cnt <= '0;
      duty_cur   <= '0;
      dir_out    <= DIR_FWD;
      pwm_out    <= 1'b0;
    end else begin
      state      <= state_nx;
      period_cnt <= cnt_nx;
      duty_cur   <= duty_nx;
      dir_out    <= dir_nx;
      pwm_out    <= pwm_nx;
    end
  end

  assign busy = !((state == IDLE) || (state == RUN));

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Bench for motor_pwm_ramp at WIDTH=4, RAMP_STEP=1. tick_in is a divided
// clock generated here; a behavioural model tracks ticks, periods and the
// ramp/reversal rules and is compared with the DUT every cycle.
module tb_motor_pwm_ramp;

  localparam int W      = 4;
  localparam int MAXD   = 15;
  localparam int DEAD_T = 4;

  localparam int M_IDLE = 0;
  localparam int M_RAMP = 1;
  localparam int M_RUN  = 2;
  localparam int M_REV  = 3;
  localparam int M_DEAD = 4;

  logic         clk      = 1'b0;
  logic         reset    = 1'b0;
  logic         tick_in  = 1'b0;
  logic         enable   = 1'b0;
  logic         dir_cmd  = 1'b1;
  logic [W-1:0] duty_cmd = '0;
  logic         pwm_out;
  logic         dir_out;
  logic [W-1:0] duty_cur;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_mode, m_cnt, m_duty, m_dir, m_pwm, m_dead;
  int due[$];
  int div_cnt  = 0;
  int div_half = 2;

  motor_pwm_ramp #(
    .WIDTH          (W),
    .RAMP_STEP      (1),
    .DEADTIME_TICKS (DEAD_T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .enable   (enable),
    .duty_cmd (duty_cmd),
    .dir_cmd  (dir_cmd),
    .pwm_out  (pwm_out),
    .dir_out  (dir_out),
    .duty_cur (duty_cur),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_duty = 0; m_dir = 1; m_pwm = 0; m_dead = 0;
    due.delete();
  endtask

  // Behaviour at one clk edge: a tick lands 3 clocks after tick_in rises;
  // every 15th tick closes a period, where duty moves one step.
  task automatic model_edge();
    bit tick, wrap, match;
    int tgt;
    tick = 0;
    foreach (due[i]) due[i]--;
    if (due.size() > 0 && due[0] == 0) begin
      void'(due.pop_front());
      tick = 1;
    end
    if (!reset) begin
      model_reset();
      return;
    end
    match = (dir_cmd == m_dir[0]);
    if (!enable) begin
      m_mode = M_IDLE; m_cnt = 0; m_duty = 0;
    end else if (m_mode == M_IDLE) begin
      m_dir  = dir_cmd;
      m_mode = M_RAMP;
    end else begin
      wrap = tick && (m_cnt == MAXD - 1);
      if (tick) m_cnt = (m_cnt + 1) % MAXD;
      if (m_mode == M_DEAD) begin
        if (tick) m_dead++;
        if (match) m_mode = M_RAMP;
        else if (m_dead == DEAD_T) begin m_dir = 1 - m_dir; m_mode = M_RAMP; end
      end else begin
        tgt = match ? int'(duty_cmd) : 0;
        if (wrap) begin
          if (m_duty < tgt) m_duty++;
          else if (m_duty > tgt) m_duty--;
        end
        if (!match) begin
          if (wrap && m_duty == 0) begin
`ifdef MOTOR_PWM_DEADTIME_EN
            m_mode = M_DEAD; m_dead = 0;
`else
            m_dir = 1 - m_dir; m_mode = M_RAMP;
`endif
          end else m_mode = M_REV;
        end else m_mode = (m_duty == int'(duty_cmd)) ? M_RUN : M_RAMP;
      end
    end
    m_pwm = (enable && m_cnt < m_duty) ? 1 : 0;
  endtask

  task automatic compare();
    chk("pwm_out",  pwm_out,  m_pwm);
    chk("dir_out",  dir_out,  m_dir);
    chk("duty_cur", duty_cur, m_duty);
    chk("busy",     busy,     (m_mode == M_RAMP || m_mode == M_REV || m_mode == M_DEAD) ? 1 : 0);
  endtask

  task automatic drive_tick();
    if (!reset) begin
      tick_in = 1'b0; div_cnt = 0;
    end else begin
      div_cnt++;
      if (div_cnt >= div_half) begin
        div_cnt = 0;
        tick_in = ~tick_in;
        if (tick_in) due.push_back(3);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    drive_tick();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_duty(input string name, input int v, input int budget);
    int k = 0;
    while (int'(duty_cur) != v && k < budget) begin step(); k++; end
    chk(name, duty_cur, v);
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin step(); if (pwm_out) hi++; end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pwm"},  pwm_out,  0);
    chk({tag, "_dir"},  dir_out,  1);
    chk({tag, "_duty"}, duty_cur, 0);
    chk({tag, "_busy"}, busy,     0);
  endtask

  initial begin
    int hi, k, prev, seq[$];
    model_reset();

    // Reset held, then released with enable low.
    run(5);
    chk_reset_vals("in_reset");
    reset = 1'b1;
    run(40);
    chk_reset_vals("idle_after_reset");

    // Ramp up to 4: one step per period boundary.
    enable = 1'b1; duty_cmd = 4'd4; dir_cmd = 1'b1;
    prev = 0; k = 0;
    while (duty_cur != 4'd4 && k < 600) begin
      step(); k++;
      if (int'(duty_cur) != prev) begin prev = duty_cur; seq.push_back(prev); end
    end
    chk("ramp4_nsteps", seq.size(), 4);
    for (int i = 0; i < seq.size(); i++) chk("ramp4_step_value", seq[i], i + 1);
    step();
    chk("ramp4_run_busy", busy, 0);
    count_pwm(60, hi);
    chk("duty4_pwm_high_clks", hi, 16);

    // Full scale then back to zero.
    duty_cmd = 4'd15;
    run_until_duty("reach15", 15, 1100);
    count_pwm(60, hi);
    chk("duty15_pwm_high_clks", hi, 60);
    duty_cmd = 4'd0;
    run_until_duty("reach0", 0, 1100);
    count_pwm(120, hi);
    chk("duty0_pwm_high_clks", hi, 0);
    chk("duty0_no_wrap", duty_cur, 0);

    // Reversal from RUN at duty 3.
    duty_cmd = 4'd3;
    run_until_duty("reach3", 3, 600);
    dir_cmd = 1'b0;
    k = 0;
    while (dir_out !== 1'b0 && k < 900) begin step(); k++; end
    chk("rev_dir_flipped", dir_out, 0);
    chk("rev_duty_zero_at_flip", duty_cur, 0);
    run_until_duty("rev_rampup3", 3, 600);
    chk("rev_dir_kept", dir_out, 0);

    // Enable drop mid-period at duty 8.
    duty_cmd = 4'd8;
    run_until_duty("reach8", 8, 600);
    run($urandom_range(5, 40));
    enable = 1'b0;
    step();
    chk("endrop_duty", duty_cur, 0);
    chk("endrop_pwm", pwm_out, 0);
    chk("endrop_busy", busy, 0);
    chk("endrop_dir_held", dir_out, 0);
    run(10);

    // Enable from IDLE with a new direction: applied immediately.
    enable = 1'b1; dir_cmd = 1'b1; duty_cmd = 4'd10;
    step();
    chk("idle_dir_immediate", dir_out, 1);
    run(150);
    chk("midramp_busy", busy, 1);
    // Async reset mid-RAMP: outputs clear before the next clk edge.
    reset = 1'b0; tick_in = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    run(3);
    reset = 1'b1;
    run(10);

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      enable   = ($urandom_range(0, 9) != 0);
      duty_cmd = W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) dir_cmd = ~dir_cmd;
      div_half = $urandom_range(2, 3);
      run($urandom_range(30, 500));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
